// File: rtl/testbus_capture.sv
// Triggered capture of the datapath testbus into a small buffer, drained over valid/ready.
// Optional per-sample 16-bit timestamp when TESTBUS_CAPTURE_TSTAMP_EN is defined.
module testbus_capture #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1,
`ifdef TESTBUS_CAPTURE_TSTAMP_EN
  localparam int DW   = W + 16
`else
  localparam int DW   = W
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic [W-1:0]  testbus,
  input  logic          arm,
  input  logic          abort,
  input  logic [W-1:0]  trig_value,
  input  logic [W-1:0]  trig_mask,
  input  logic [LW-1:0] capture_len,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic [1:0]    state_o,
  output logic          done
);

  // state      | meaning
  // ST_IDLE    | waiting for arm
  // ST_ARMED   | watching qualified samples for the masked trigger match
  // ST_CAPTURE | storing consecutive qualified samples until L are held
  // ST_DRAIN   | streaming stored samples out, one per accepted transfer
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  localparam int PW = $clog2(DEPTH);

  state_t         state, state_nx;
  logic [W-1:0]   value_q, mask_q;
  logic [LW-1:0]  len_q, len_eff;
  logic [LW-1:0]  count, count_inc;
  logic [LW-1:0]  rd_cnt;
  logic [DW-1:0]  wdata;
  logic [DW-1:0]  mem [DEPTH];
  logic           trig_hit, wr_en, cap_last, xfer, last_xfer;

`ifdef TESTBUS_CAPTURE_TSTAMP_EN
  logic [15:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ts_q <= '0;
    else if (clk_en) ts_q <= ts_q + 16'd1;
  end

  assign wdata = {ts_q, testbus};
`else
  assign wdata = testbus;
`endif

  always_comb begin
    len_eff = capture_len;
    if (capture_len == '0 || capture_len > LW'(DEPTH)) len_eff = LW'(DEPTH);
  end

  // In ARMED count is 0, so count_inc == len_q also covers the L==1 case.
  assign trig_hit  = ((testbus ^ value_q) & mask_q) == '0;
  assign wr_en     = clk_en && !abort &&
                     ((state == ST_ARMED && trig_hit) || state == ST_CAPTURE);
  assign count_inc = count + LW'(1);
  assign cap_last  = count_inc == len_q;
  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && (rd_cnt == len_q - LW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (arm) state_nx = ST_ARMED;
      ST_ARMED,
      ST_CAPTURE: if (wr_en) state_nx = cap_last ? ST_DRAIN : ST_CAPTURE;
      ST_DRAIN:   if (last_xfer) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[count[PW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q   <= '0;
      mask_q    <= '0;
      len_q     <= '0;
      count     <= '0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        count     <= '0;
        rd_cnt    <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (arm) begin
              value_q <= trig_value;
              mask_q  <= trig_mask;
              len_q   <= len_eff;
              count   <= '0;
              rd_cnt  <= '0;
            end
          end
          ST_ARMED, ST_CAPTURE: begin
            if (wr_en) begin
              count <= count_inc;
              if (cap_last) begin
                // Slot 0 is being written on this same edge when L==1.
                out_valid <= 1'b1;
                out_data  <= (count == '0) ? wdata : mem[0];
                rd_cnt    <= '0;
              end
            end
          end
          ST_DRAIN: begin
            if (last_xfer) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              count     <= '0;
              rd_cnt    <= '0;
            end else if (xfer) begin
              rd_cnt   <= rd_cnt + LW'(1);
              out_data <= mem[rd_cnt[PW-1:0] + PW'(1)];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy    = state != ST_IDLE;
  assign state_o = state;

endmodule

// File: tb/tb_testbus_capture.sv
// Bench for testbus_capture: scenario table, hand sequences and randomized runs
// checked against a history-based model of the trigger/capture rules.
module tb_testbus_capture;
  localparam int W     = 16;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef TESTBUS_CAPTURE_TSTAMP_EN
  localparam int DW    = W + 16;
`else
  localparam int DW    = W;
`endif
  localparam int BUDGET = 400;

  logic          clk, rst_n, clk_en, arm, abort, out_ready;
  logic [W-1:0]  testbus, trig_value, trig_mask;
  logic [LW-1:0] capture_len;
  logic          out_valid, busy, done;
  logic [DW-1:0] out_data;
  logic [1:0]    state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] ts_model;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]  value;
    logic [W-1:0]  mask;
    logic [LW-1:0] len;
    logic [W-1:0]  tb_start;
    logic          tb_rand;
    int            en_mode;   // 0 always, 1 even cycles, 2 random, 3 odd cycles
    int            rdy_mode;  // 0 always, 1 pattern from first valid cycle, 2 random
    logic [7:0]    rdy_pat;
    int            exp_n;
    logic          chk_first;
    logic [W-1:0]  exp_first;
  } scen_t;

  testbus_capture #(.W(W), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .testbus(testbus),
    .arm(arm), .abort(abort), .trig_value(trig_value), .trig_mask(trig_mask),
    .capture_len(capture_len), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .state_o(state_o), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timestamp reference: counts qualified edges since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ts_model <= '0;
    else if (clk_en) ts_model <= ts_model + 16'd1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mkword(input logic [W-1:0] tb);
`ifdef TESTBUS_CAPTURE_TSTAMP_EN
    return {ts_model, tb};
`else
    return tb;
`endif
  endfunction

  task automatic run(input string nm, input scen_t s);
    logic [W-1:0]  hist_tb[$];
    logic          hist_en[$];
    logic [DW-1:0] hist_w[$];
    logic [DW-1:0] stall_data, w;
    logic          stall_prev, done_ok, drain_ok;
    int eff_l, cyc, d, first_valid, done_cyc, n_done, last_x, k_trig, k_last;
    eff_l = (s.len == 0 || s.len > DEPTH) ? DEPTH : int'(s.len);
    got_q.delete();
    exp_q.delete();
    arm = 1'b1; trig_value = s.value; trig_mask = s.mask; capture_len = s.len;
    clk_en = 1'b1; testbus = s.tb_start - 16'd1; out_ready = 1'b1;
    tick();
    arm = 1'b0; trig_value = ~s.value; trig_mask = ~s.mask; capture_len = s.len + 5'd1;
    cyc = 0; first_valid = -1; done_cyc = -1; n_done = 0; last_x = -1;
    stall_prev = 1'b0; stall_data = '0; done_ok = 1'b0; drain_ok = 1'b0;
    while (cyc < BUDGET) begin
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          done_ok = !out_valid && state_o == 2'd0 && !busy;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 2) break;
      if (stall_prev) chk($sformatf("%s hold c%0d", nm, cyc), out_data, stall_data);
      if (out_valid && first_valid < 0) begin
        first_valid = cyc;
        drain_ok = state_o == 2'd3 && busy;
      end
      d = (first_valid < 0) ? -1 : cyc - first_valid;
      case (s.en_mode)
        0: clk_en = 1'b1;
        1: clk_en = (cyc % 2) == 0;
        3: clk_en = (cyc % 2) == 1;
        default: clk_en = $urandom_range(0, 3) != 0;
      endcase
      testbus = s.tb_rand ? W'($urandom) : s.tb_start + W'(cyc);
      case (s.rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = (d >= 0 && d < 8) ? s.rdy_pat[d] : 1'b1;
        default: out_ready = $urandom_range(0, 2) != 0;
      endcase
      hist_tb.push_back(testbus);
      hist_en.push_back(clk_en);
      hist_w.push_back(mkword(testbus));
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_x = cyc;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    chk({nm, " finished"}, done_cyc >= 0, 1'b1);
    if (done_cyc < 0) begin
      abort = 1'b1; tick(); abort = 1'b0; tick();
    end
    // Model: first qualified sample matching under mask, then the next L-1 qualified samples.
    k_trig = -1; k_last = -1;
    for (int j = 0; j < hist_tb.size(); j++) begin
      if (!hist_en[j]) continue;
      if (k_trig < 0) begin
        if (((hist_tb[j] ^ s.value) & s.mask) == '0) begin
          k_trig = j; k_last = j; exp_q.push_back(hist_w[j]);
        end
      end else if (exp_q.size() < eff_l) begin
        k_last = j; exp_q.push_back(hist_w[j]);
      end
    end
    chk({nm, " words"}, got_q.size(), s.exp_n);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s word%0d", nm, i), got_q[i], exp_q[i]);
    if (s.chk_first && got_q.size() > 0) begin
      w = got_q[0];
      chk({nm, " first"}, w[W-1:0], s.exp_first);
    end
    chk({nm, " valid latency"}, first_valid, k_last + 1);
    chk({nm, " drain state"}, drain_ok, 1'b1);
    chk({nm, " done pulses"}, n_done, 1);
    chk({nm, " done after last"}, done_cyc, last_x + 1);
    chk({nm, " idle at done"}, done_ok, 1'b1);
    if (s.rdy_mode == 0) chk({nm, " throughput"}, done_cyc, k_last + 1 + eff_l);
  endtask

  scen_t vec[6];
  string names[6];

  initial begin
    logic          saw_v, saw_d, saw_s;
    logic [DW-1:0] w;
    scen_t         rs;
    int            guard;

    vec[0] = '{16'h00A5, 16'hFFFF, 5'd4,  16'h00A3, 1'b0, 0, 0, 8'h00, 4,  1'b1, 16'h00A5};
    vec[1] = '{16'h00A5, 16'hFFFF, 5'd4,  16'h00A3, 1'b0, 1, 0, 8'h00, 4,  1'b1, 16'h00A5};
    vec[2] = '{16'h00A5, 16'hFFFF, 5'd3,  16'h00A3, 1'b0, 0, 1, 8'h34, 3,  1'b1, 16'h00A5};
    vec[3] = '{16'h0102, 16'hFFFF, 5'd0,  16'h0100, 1'b0, 0, 0, 8'h00, 16, 1'b1, 16'h0102};
    vec[4] = '{16'h0102, 16'hFFFF, 5'd19, 16'h0100, 1'b0, 0, 2, 8'h00, 16, 1'b1, 16'h0102};
    vec[5] = '{16'h5555, 16'h0000, 5'd1,  16'h0777, 1'b0, 3, 0, 8'h00, 1,  1'b1, 16'h0778};
    names[0] = "basic"; names[1] = "gated"; names[2] = "backpressure";
    names[3] = "len0";  names[4] = "len19"; names[5] = "len1_mask0";

    rst_n = 1'b0; clk_en = 1'b0; arm = 1'b0; abort = 1'b0; out_ready = 1'b0;
    testbus = '0; trig_value = '0; trig_mask = '0; capture_len = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_data", out_data, '0);
    chk("reset busy", busy, 1'b0);
    chk("reset state", state_o, 2'd0);
    chk("reset done", done, 1'b0);

    for (int i = 0; i < 6; i++) run(names[i], vec[i]);

    // Abort in CAPTURE with a simultaneous arm.
    arm = 1'b1; trig_value = 16'h00A5; trig_mask = 16'hFFFF; capture_len = 5'd4;
    testbus = 16'h00A2; clk_en = 1'b1; out_ready = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 4; k++) begin
      testbus = 16'h00A3 + 16'(k);
      tick();
    end
    chk("abort pre state", state_o, 2'd2);
    abort = 1'b1; arm = 1'b1; testbus = 16'h00A7;
    tick();
    abort = 1'b0; arm = 1'b0;
    chk("abort state", state_o, 2'd0);
    chk("abort busy", busy, 1'b0);
    chk("abort valid", out_valid, 1'b0);
    saw_v = 1'b0; saw_d = 1'b0; saw_s = 1'b0;
    for (int k = 0; k < 6; k++) begin
      testbus = 16'h00A5;
      if (out_valid) saw_v = 1'b1;
      if (done) saw_d = 1'b1;
      if (state_o != 2'd0) saw_s = 1'b1;
      tick();
    end
    chk("abort no valid", saw_v, 1'b0);
    chk("abort no done", saw_d, 1'b0);
    chk("abort stays idle", saw_s, 1'b0);

    // Arm while busy is ignored; abort in DRAIN gives no done.
    arm = 1'b1; trig_value = 16'h1234; trig_mask = 16'hFFFF; capture_len = 5'd2;
    testbus = 16'h0000;
    tick();
    arm = 1'b0;
    tick();
    arm = 1'b1; trig_mask = 16'h0000; trig_value = 16'h0000; capture_len = 5'd1;
    tick();
    arm = 1'b0;
    tick();
    chk("arm busy ignored", state_o, 2'd1);
    testbus = 16'h1234; tick();
    testbus = 16'h1235; out_ready = 1'b0; tick();
    chk("arm busy drain", state_o, 2'd3);
    w = out_data;
    chk("arm busy data", w[W-1:0], 16'h1234);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("drain abort done", done, 1'b0);
    chk("drain abort valid", out_valid, 1'b0);
    tick();
    chk("drain abort no done", done, 1'b0);
    out_ready = 1'b1;

    // Asynchronous reset during DRAIN.
    arm = 1'b1; trig_mask = 16'h0000; capture_len = 5'd4; out_ready = 1'b0;
    tick();
    arm = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick(); guard++;
    end
    chk("rst mid reached drain", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst mid state", state_o, 2'd0);
    chk("rst mid valid", out_valid, 1'b0);
    chk("rst mid busy", busy, 1'b0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    chk("rst mid stays idle", state_o, 2'd0);

    for (int r = 0; r < 12; r++) begin
      rs.value     = W'($urandom);
      rs.mask      = (W'(1) << $urandom_range(0, W-1)) |
                     (($urandom_range(0, 1) != 0) ? (W'(1) << $urandom_range(0, W-1)) : W'(0));
      rs.len       = LW'($urandom_range(0, 31));
      rs.tb_start  = '0;
      rs.tb_rand   = 1'b1;
      rs.en_mode   = 2;
      rs.rdy_mode  = 2;
      rs.rdy_pat   = '0;
      rs.exp_n     = (rs.len == 0 || rs.len > DEPTH) ? DEPTH : int'(rs.len);
      rs.chk_first = 1'b0;
      rs.exp_first = '0;
      run($sformatf("rand%0d", r), rs);
    end

`ifdef TESTBUS_CAPTURE_TSTAMP_EN
    clk_en = 1'b1; arm = 1'b0;
    guard = 0;
    while (ts_model != 16'hFFFC && guard < 70000) begin
      tick(); guard++;
    end
    rs = '{16'h0301, 16'hFFFF, 5'd3, 16'h0300, 1'b0, 0, 0, 8'h00, 3, 1'b1, 16'h0301};
    run("tstamp", rs);
    if (got_q.size() == 3) begin
      w = got_q[0]; chk("tstamp ts0", w[DW-1:W], 16'hFFFE);
      w = got_q[1]; chk("tstamp ts1", w[DW-1:W], 16'hFFFF);
      w = got_q[2]; chk("tstamp ts2", w[DW-1:W], 16'h0000);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
